// File: rtl/operand_entry_pkg.sv
// Shared definitions for the operand entry block: FSM state codes, the state
// type, the operand width and the default debounce length.
package operand_entry_pkg;

    typedef logic [1:0] state_t;

    localparam state_t WAIT_A = 2'b00;
    localparam state_t WAIT_B = 2'b01;
    localparam state_t DONE   = 2'b10;

    localparam int DATA_W                  = 4;
    // 10 ms at 50 MHz
    localparam int DEBOUNCE_CYCLES_DEFAULT = 500000;

endpackage

// File: rtl/operand_entry_key_debounce.sv
// Push-button conditioner: 2-flop synchronizer, stability counter and
// press-edge detector producing one single-cycle Press per accepted press.
module key_debounce
    import operand_entry_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic Clock,
    input  logic Resetn,
    input  logic KEY_n,
    output logic Press
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

    logic             sync1;
    logic             sync2;
    logic             level;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;

    assign cnt_nxt = cnt + CNT_W'(1);

    // Idle level is 1 (released) so a button held through reset reads as a
    // fresh press once reset lifts.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            level <= 1'b1;
            cnt   <= '0;
            Press <= 1'b0;
        end else begin
            sync1 <= KEY_n;
            sync2 <= sync1;
            Press <= 1'b0;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt_nxt == CNT_MAX) begin
                // Press fires on the same edge the level falls, so it is high
                // during the cycle right after the debounced transition.
                level <= sync2;
                cnt   <= '0;
                Press <= level & ~sync2;
            end else begin
                cnt <= cnt_nxt;
            end
        end
    end

endmodule

// File: rtl/operand_entry.sv
// Operand entry: collects multiplicand A then multiplier B from the switches on
// successive debounced presses of Load, then flags the pair valid.
module operand_entry
    import operand_entry_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic              Clock,
    input  logic              Resetn,
    input  logic [DATA_W-1:0] SW,
    input  logic              Load,
    output logic [DATA_W-1:0] A,
    output logic [DATA_W-1:0] B,
    output logic              Valid,
    output logic [1:0]        Stage
);

    state_t state;
    logic   press;

    key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key_debounce (
        .Clock  (Clock),
        .Resetn (Resetn),
        .KEY_n  (Load),
        .Press  (press)
    );

    // SW is quasi-static and only sampled on the press edge, so it needs no
    // synchronizer of its own.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state <= WAIT_A;
            A     <= '0;
            B     <= '0;
            Valid <= 1'b0;
        end else begin
            case (state)
                WAIT_A: begin
                    if (press) begin
                        A     <= SW;
                        state <= WAIT_B;
                        Valid <= 1'b0;
                    end
                end
                WAIT_B: begin
                    if (press) begin
                        B     <= SW;
                        state <= DONE;
                        Valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (press) begin
                        state <= WAIT_A;
                        Valid <= 1'b0;
                    end
                end
                default: begin
                    state <= WAIT_A;
                    Valid <= 1'b0;
                end
            endcase
        end
    end

    assign Stage = state;

endmodule

// File: tb/tb_operand_entry.sv
// Directed bench for operand_entry with a short debounce; expected output
// tuples are queued when a press is driven and popped when the DUT updates.
module tb_operand_entry;
    import operand_entry_pkg::*;

    localparam int D = 4;

    logic       Clock = 1'b0;
    logic       Resetn;
    logic       Load;
    logic [3:0] SW;
    logic [3:0] A;
    logic [3:0] B;
    logic       Valid;
    logic [1:0] Stage;

    int checks   = 0;
    int failures = 0;

    logic [10:0] exp_q[$];
    logic [1:0]  m_st;
    logic [3:0]  m_a;
    logic [3:0]  m_b;

    always #5 Clock = ~Clock;

    operand_entry #(.DEBOUNCE_CYCLES(D)) dut (
        .Clock  (Clock),
        .Resetn (Resetn),
        .SW     (SW),
        .Load   (Load),
        .A      (A),
        .B      (B),
        .Valid  (Valid),
        .Stage  (Stage)
    );

    function automatic logic [10:0] obs();
        return {Stage, Valid, A, B};
    endfunction

    function automatic logic [10:0] model_tup();
        return {m_st, (m_st == DONE), m_a, m_b};
    endfunction

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        checks++;
        assert (o === e) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    task automatic model_reset();
        m_st = WAIT_A;
        m_a  = 4'h0;
        m_b  = 4'h0;
        exp_q.delete();
    endtask

    task automatic model_pulse(input logic [3:0] sw);
        case (m_st)
            WAIT_A:  begin m_a = sw; m_st = WAIT_B; end
            WAIT_B:  begin m_b = sw; m_st = DONE;   end
            default: m_st = WAIT_A;
        endcase
        exp_q.push_back(model_tup());
    endtask

    // Load is already low; edge 1 is the next rising edge.
    task automatic watch(input int hold, input int exp_changes);
        logic [10:0] prev;
        logic [10:0] cur;
        int changes;
        prev    = obs();
        changes = 0;
        for (int e = 1; e <= hold; e++) begin
            @(posedge Clock);
            @(negedge Clock);
            cur = obs();
            if (cur !== prev) begin
                changes++;
                if (exp_q.size() > 0) begin
                    chk("scoreboard", 32'(cur), 32'(exp_q.pop_front()));
                    chk("latency_edge", e, D + 3);
                end else begin
                    chk("unexpected_update", 32'(cur), 32'(prev));
                end
                prev = cur;
            end
        end
        chk("update_count", changes, exp_changes);
    endtask

    task automatic idle(input int n);
        logic [10:0] prev;
        prev = obs();
        for (int i = 0; i < n; i++) begin
            @(posedge Clock);
            #1 SW = 4'($urandom_range(15, 0));
            @(negedge Clock);
            if (obs() !== prev) chk("spurious_update", 32'(obs()), 32'(prev));
        end
        chk("hold_state", 32'(obs()), 32'(model_tup()));
        chk("queue_drained", exp_q.size(), 0);
    endtask

    task automatic press(input logic [3:0] sw, input int hold);
        @(posedge Clock);
        #1;
        SW   = sw;
        Load = 1'b0;
        model_pulse(sw);
        watch(hold, 1);
        Load = 1'b1;
        idle(D + 8);
    endtask

    task automatic do_reset();
        Resetn = 1'b0;
        Load   = 1'b1;
        model_reset();
        #1 chk("reset_async", 32'(obs()), 32'(0));
        repeat (3) @(posedge Clock);
        #1 Resetn = 1'b1;
    endtask

    initial begin
        Resetn = 1'b1;
        Load   = 1'b1;
        SW     = 4'h0;
        #2;

        // Reset then idle
        do_reset();
        idle(30);

        // Full entry
        press(4'h7, 10);
        chk("stage_after_a", 32'(Stage), 32'(WAIT_B));
        press(4'hB, 10);
        chk("valid_done", 32'(Valid), 32'(1));

        // Wrap from DONE
        do_reset();
        press(4'h3, 10);
        press(4'h5, 10);
        press(4'h0, 10);
        chk("wrap_valid", 32'(Valid), 32'(0));
        chk("wrap_ab", 32'({A, B}), 32'(8'h35));
        press(4'hF, 10);
        chk("wrap_a_reload", 32'(A), 32'(4'hF));

        // Bounce rejection
        do_reset();
        for (int i = 0; i < 10; i++) begin
            @(posedge Clock);
            #1 Load = (i % 2 == 0) ? 1'b0 : 1'b1;
            @(posedge Clock);
        end
        #1 Load = 1'b1;
        idle(20);

        // Long hold
        press(4'h6, 100);
        chk("long_hold_a", 32'(A), 32'(4'h6));

        // Reset mid-debounce while in WAIT_B
        press(4'h2, 10);
        @(posedge Clock);
        #1 Load = 1'b0;
        repeat (4) @(posedge Clock);
        #3 Resetn = 1'b0;
        model_reset();
        #1 chk("reset_midop", 32'(obs()), 32'(0));
        Load = 1'b1;
        repeat (3) @(posedge Clock);
        #1 Resetn = 1'b1;
        idle(20);
        press(4'h9, 10);

        // Button held through reset release counts as one new press
        @(posedge Clock);
        #1;
        Resetn = 1'b0;
        Load   = 1'b0;
        model_reset();
        repeat (3) @(posedge Clock);
        #1;
        Resetn = 1'b1;
        SW     = 4'hC;
        model_pulse(4'hC);
        watch(20, 1);
        Load = 1'b1;
        idle(D + 8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/operand_entry.md
OPERAND_ENTRY -- requirements
Module: operand_entry

Interface
REQ-001 Parameter: DEBOUNCE_CYCLES, default 500000, is the number of consecutive cycles the synchronized Load level must differ from the debounced level before it is accepted (10 ms at 50 MHz); legal range is 1 or more.
REQ-002 Port: Clock, input, 1 bit, the single system clock; all flops SHALL use its rising edge.
REQ-003 Port: Resetn, input, 1 bit, asynchronous active-low reset.
REQ-004 Port: SW, input, 4 bits, operand value from the slide switches; quasi-static, not synchronized.
REQ-005 Port: Load, input, 1 bit, push button, active-low (low means pressed), asynchronous to Clock and bouncy.
REQ-006 Port: A, output, 4 bits, registered multiplicand, consumed by the downstream mult.
REQ-007 Port: B, output, 4 bits, registered multiplier, consumed by the downstream mult.
REQ-008 Port: Valid, output, 1 bit, registered; high while A and B form a complete operand pair.
REQ-009 Port: Stage, output, 2 bits, registered current state code, for LEDR.

Function
REQ-010 Load SHALL pass through a 2-flop synchronizer (sync1, then sync2) before any other use.
REQ-011 The debounce counter SHALL clear on every cycle where sync2 equals the debounced level.
REQ-012 Otherwise the counter SHALL increment, and the debounced level SHALL take sync2's value on the edge where the count reaches DEBOUNCE_CYCLES, with the counter clearing on that same edge.
REQ-013 A press pulse SHALL be a single cycle, high in the cycle after the debounced level goes from 1 to 0; release SHALL produce no pulse.
REQ-014 A held button SHALL yield exactly one pulse, regardless of hold length.
REQ-015 Load low pulses shorter than DEBOUNCE_CYCLES synchronized cycles SHALL produce no pulse and no state change.
REQ-016 Latency: with Load held low from the first sampling edge (edge 1), the FSM and outputs SHALL update on rising edge DEBOUNCE_CYCLES+3.
REQ-017 FSM states and Stage encodings: WAIT_A = 00, WAIT_B = 01, DONE = 10; code 11 is illegal and SHALL recover to WAIT_A on the next edge.
REQ-018 In WAIT_A, a pulse SHALL load A from SW, keep B unchanged, and move to WAIT_B.
REQ-019 In WAIT_B, a pulse SHALL load B from SW, keep A unchanged, and move to DONE.
REQ-020 In DONE, a pulse SHALL move to WAIT_A, keeping both A and B unchanged.
REQ-021 With no pulse, all registers SHALL hold their values.
REQ-022 Valid SHALL be 1 exactly when the state is DONE; it is registered and updates on the same edge as the state.
REQ-023 SW SHALL be sampled only on the edge where the pulse is high; SW changes at any other time SHALL have no effect.
REQ-024 A and B SHALL never be reset except by Resetn.

Reset
REQ-025 While Resetn is low, the block SHALL asynchronously force: A = 0, B = 0, Valid = 0, Stage = 00 (WAIT_A), sync1 = 1, sync2 = 1, debounced level = 1, counter = 0, pulse = 0.
REQ-026 A reset asserted mid-debounce or mid-entry SHALL discard the partial press and any partial operand pair.
REQ-027 After reset release, a button still held low SHALL be debounced as a new press, producing exactly one pulse.
REQ-028 Reset deassertion SHALL be treated as synchronous to Clock by the integration, which is outside this block's scope.

Structure
REQ-029 A shared package SHALL hold: the state encodings WAIT_A, WAIT_B and DONE; the 2-bit state type; and the DEBOUNCE_CYCLES default.
REQ-030 The synchronizer, debounce counter and edge detector SHALL form one sub-module, key_debounce (ports: Clock, Resetn, KEY_n, Press), which outputs the single-cycle pulse.
REQ-031 The counter width SHALL be clog2(DEBOUNCE_CYCLES+1) bits.
REQ-032 operand_entry SHALL instantiate key_debounce and contain the FSM and the operand registers; no other hierarchy is permitted.

Verification (DEBOUNCE_CYCLES = 4)
REQ-033 Reset then idle: Resetn low for 3 cycles, then high, Load=1 -> A=0, B=0, Valid=0, Stage=00 held indefinitely.
REQ-034 Full entry: SW=4'h7, press Load low for 10 cycles, release, SW=4'hB, press again -> A=7 at edge 7 of the first press, Stage=01; then B=B, Valid=1, Stage=10.
REQ-035 Bounce rejection: Load toggles low/high every 2 cycles for 20 cycles, then stays high -> no pulse, Stage stays 00, A stays 0.
REQ-036 Long hold: Load low for 100 cycles in WAIT_A -> exactly one transition to 01, with A loaded once.
REQ-037 Wrap: from DONE (A=3, B=5), press once -> Stage=00, Valid=0, A=3, B=5; the next press with SW=4'hF -> A=F.
REQ-038 Reset mid-operation: in WAIT_B with Load low for 2 debounce cycles, assert Resetn -> all reset values immediately, no pulse, and a fresh press is needed after release.
